// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: latches a request, holds
// stall for LATENCY+1 cycles, then pulses ready (and err) for one cycle.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  stall,
    output logic                  err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  errp_q, errp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we_s;
    logic                  req_s;
    logic                  stall_s;
    logic                  addr_unused_s;

    assign req_s         = mem_read | mem_write;
    assign addr_unused_s = ^addr[31:ADDR_BITS+2];

    // Next-state logic for the request FSM and its latched request copy.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        errp_d   = errp_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        mem_we_s = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stall is combinational here so the pipeline freezes the same cycle.
                stall_s = req_s;
                if (req_s) begin
                    op_wr_d = mem_write;
                    idx_d   = addr[ADDR_BITS+1:2];
                    wdata_d = write_data;
                    errp_d  = (addr[1:0] != 2'b00) | (mem_read & mem_write);
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_s = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    err_d   = errp_q;
                    if (op_wr_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, request latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            errp_q  <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            errp_q  <= errp_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage array; reset clears every word and discards any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign stall     = stall_s & ~reset;
    assign read_data = rdata_q;
    assign ready     = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed plan plus randomized requests
// checked against an array-based model of the memory.
module tb_dmem_responder;

    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic        stall;
    logic        err;

    int          vec = 0;
    int          misc = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        sb_q[$];

    logic [31:0] mdl_mem [16];
    logic [31:0] mdl_rd;

    logic        mon_stall;
    logic        mon_ready;
    exp_t        mon_e;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(4), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .ready(ready), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
        mdl_rd = 32'd0;
    endtask

    // Called at posedge+1: drive a request, push its expectation, wait for completion.
    task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        bit   done;
        idx = int'(a[5:2]);
        e.err = (a[1:0] != 2'b00) || (r && w);
        if (w) begin
            mdl_mem[idx] = d;
        end else begin
            mdl_rd = mdl_mem[idx];
        end
        e.rd = mdl_rd;
        e.issue = cyc;
        sb_q.push_back(e);
        mem_read = r;
        mem_write = w;
        addr = a;
        write_data = d;
        done = 1'b0;
        for (int k = 0; k < LAT + 6 && !done; k++) begin
            @(posedge clk);
            #1;
            if (ready) done = 1'b1;
        end
        if (!done) begin
            vec++;
            misc++;
            $display("FAIL timeout addr=%h: ready never seen (required within %0d cycles)", a, LAT + 1);
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = $urandom;
        write_data = $urandom;
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle stall/ready timing, and data/err on every ready pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb_q.size() > 0) begin
                mon_stall = (cyc >= sb_q[0].issue) && (cyc <= sb_q[0].issue + LAT);
                mon_ready = (cyc == sb_q[0].issue + LAT + 1);
            end else begin
                mon_stall = 1'b0;
                mon_ready = 1'b0;
            end
            vec++;
            if (stall !== mon_stall) begin
                misc++;
                $display("FAIL stall cyc=%0d: got %b expected %b", cyc, stall, mon_stall);
            end
            vec++;
            if (ready !== mon_ready) begin
                misc++;
                $display("FAIL ready cyc=%0d: got %b expected %b", cyc, ready, mon_ready);
            end
            if (ready && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                vec++;
                if (read_data !== mon_e.rd) begin
                    misc++;
                    $display("FAIL read_data cyc=%0d: got %h expected %h", cyc, read_data, mon_e.rd);
                end
                vec++;
                if (err !== mon_e.err) begin
                    misc++;
                    $display("FAIL err cyc=%0d: got %b expected %b", cyc, err, mon_e.err);
                end
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vec++;
        if (read_data !== 32'd0 || ready !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
            misc++;
            $display("FAIL reset_state: got rd=%h rdy=%b stl=%b err=%b expected all zero",
                     read_data, ready, stall, err);
        end

        do_req(1'b1, 1'b0, 32'h0000_000C, 32'h0);
        do_req(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h0);
        do_req(1'b0, 1'b1, 32'h0000_0004, 32'h11);
        do_req(1'b0, 1'b1, 32'h0000_003C, 32'h22);
        do_req(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_003C, 32'h0);
        do_req(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE);
        do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0009, 32'h0);
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h55);
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0);

        // Reset during BUSY: outputs drop at once and the write is lost.
        sb_q.push_back('{rd: mdl_rd, err: 1'b0, issue: cyc});
        mem_write = 1'b1;
        addr = 32'h0000_000C;
        write_data = 32'h77;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vec++;
        if (stall !== 1'b0 || ready !== 1'b0) begin
            misc++;
            $display("FAIL mid_reset: got stall=%b ready=%b expected 0 0", stall, ready);
        end
        sb_q.delete();
        model_clear();
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 32'h0000_000C, 32'h0);

        for (int t = 0; t < 60; t++) begin
            logic r;
            logic w;
            int   sel;
            sel = int'($urandom_range(0, 9));
            w = (sel < 4) || (sel == 9);
            r = !w || (sel == 9);
            do_req(r, w, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (sb_q.size() != 0) begin
            misc++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
        $finish;
    end

endmodule
